// File: rtl/sc_cmd_seq_if.sv
// Pin bundle between the command sequencer and its host / register block.
// slave: the sequencer; master: whoever drives the serial bus and read data.
interface sc_cmd_seq_if;
    logic        cs_n;
    logic        si;
    logic [7:0]  dq_in;
    logic        mode;
    logic        wel;
    logic [7:0]  sc_data_out;
    logic        so;
    logic [31:0] addr;
    logic [7:0]  data_byte_in;
    logic [7:0]  pre_data1;
    logic [7:0]  pre_data2;
    logic        w_byte1, w_byte2, w_71h, en_wel, dis_wel, opi, spi;
    logic        rec_1, rec_2, rec_3, rec_1_unxp, rec_2_unxp;
    logic        r_byte1, r_65h_1, r_65h_2, r_65h_3;
    logic        cmd_err;

    modport slave (
        input  cs_n, si, dq_in, mode, wel, sc_data_out,
        output so, addr, data_byte_in, pre_data1, pre_data2,
               w_byte1, w_byte2, w_71h, en_wel, dis_wel, opi, spi,
               rec_1, rec_2, rec_3, rec_1_unxp, rec_2_unxp,
               r_byte1, r_65h_1, r_65h_2, r_65h_3, cmd_err
    );

    modport master (
        output cs_n, si, dq_in, mode, wel, sc_data_out,
        input  so, addr, data_byte_in, pre_data1, pre_data2,
               w_byte1, w_byte2, w_71h, en_wel, dis_wel, opi, spi,
               rec_1, rec_2, rec_3, rec_1_unxp, rec_2_unxp,
               r_byte1, r_65h_1, r_65h_2, r_65h_3, cmd_err
    );
endinterface

// File: rtl/sc_cmd_seq.sv
// Serial command sequencer: opcode/address/data decode and read-data shift-out.
// Define SC_OPI_EN to enable the byte-wide OPI path (selected by mode=1).
module sc_cmd_seq #(
    parameter int ADDR_BYTES = 4
) (
    input  logic         sck,
    input  logic         rst,
    sc_cmd_seq_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, OPCODE, ADDR, DIN, DOUT, IGNORE} state_t;

    typedef struct packed {
        logic w_byte1, w_byte2, w_71h, en_wel, dis_wel, opi, spi;
        logic rec_1, rec_2, rec_3, rec_1_unxp, rec_2_unxp;
        logic r_byte1, r_65h_1, r_65h_2, r_65h_3;
        logic cmd_err;
    } flags_t;

    localparam logic [31:0] AMASK = 32'hFFFF_FFFF >> (8 * (4 - ADDR_BYTES));

    state_t      state;
    flags_t      fl;
    logic [2:0]  bitcnt;
    logic [1:0]  bcnt;
    logic [6:0]  opcode;
    logic [7:0]  dsh, dbi, pd1, pd2;
    logic [31:0] addr_r;
    logic        so_r;
    logic        opi_u, unit_last;
    logic [7:0]  op_nxt, din_nxt;
    logic [31:0] addr_nxt;

`ifdef SC_OPI_EN
    logic opi_m;
    // mode is live only on the first edge; afterwards the frozen copy rules
    assign opi_u = (state == IDLE) ? bus.mode : opi_m;
`else
    assign opi_u = 1'b0;
`endif

    assign unit_last = opi_u | (bitcnt == 3'd7);

    always_comb begin
        op_nxt   = {opcode, bus.si};
        din_nxt  = {dbi[6:0], bus.si};
        addr_nxt = {addr_r[30:0], bus.si} & AMASK;
`ifdef SC_OPI_EN
        if (opi_u) begin
            op_nxt   = bus.dq_in;
            din_nxt  = bus.dq_in;
            addr_nxt = {addr_r[23:0], bus.dq_in} & AMASK;
        end
`endif
    end

    always_ff @(posedge sck) begin
        if (rst) begin
            state  <= IDLE;
            fl     <= '0;
            bitcnt <= '0;
            bcnt   <= '0;
            opcode <= '0;
            dsh    <= '0;
            dbi    <= '0;
            pd1    <= '0;
            pd2    <= '0;
            addr_r <= '0;
            so_r   <= 1'b0;
`ifdef SC_OPI_EN
            opi_m  <= 1'b0;
`endif
        end else if (bus.cs_n) begin
            state  <= IDLE;
            bitcnt <= '0;
        end else begin
            bitcnt <= unit_last ? 3'd0 : bitcnt + 3'd1;
            case (state)
                IDLE, OPCODE: begin
                    if (state == IDLE) begin
                        fl <= '0;
`ifdef SC_OPI_EN
                        opi_m <= bus.mode;
`endif
                    end
                    opcode <= op_nxt[6:0];
                    state  <= OPCODE;
                    bcnt   <= '0;
                    if (unit_last) begin
                        state <= IGNORE;
                        case (op_nxt)
                            8'h06: fl.en_wel  <= 1'b1;
                            8'h04: fl.dis_wel <= 1'b1;
                            8'hFF: fl.spi     <= 1'b1;
`ifdef SC_OPI_EN
                            8'h38: if (bus.wel) fl.opi <= 1'b1; else fl.cmd_err <= 1'b1;
`endif
                            8'h01: if (bus.wel) begin fl.w_byte1 <= 1'b1; state <= DIN; end
                                   else fl.cmd_err <= 1'b1;
                            8'h31: if (bus.wel) begin fl.w_byte2 <= 1'b1; state <= DIN; end
                                   else fl.cmd_err <= 1'b1;
                            8'h71: if (bus.wel) begin fl.w_71h <= 1'b1; state <= ADDR; end
                                   else fl.cmd_err <= 1'b1;
                            8'h05: begin fl.r_byte1 <= 1'b1; state <= DOUT; end
                            8'h65: state <= ADDR;
                            default: fl.cmd_err <= 1'b1;
                        endcase
                    end
                end
                ADDR: begin
                    addr_r <= addr_nxt;
                    if (unit_last) begin
                        if (bcnt == 2'(ADDR_BYTES - 1)) begin
                            bcnt  <= '0;
                            state <= fl.w_71h ? DIN : DOUT;
                        end else begin
                            bcnt <= bcnt + 2'd1;
                        end
                    end
                end
                DIN: begin
                    // bcnt = completed bytes; a fourth byte is dropped entirely
                    if (bcnt != 2'd3) begin
                        dbi <= din_nxt;
                        if (bitcnt == 3'd0) begin
                            pd2 <= pd1;
                            pd1 <= dbi;
                            if (bcnt == 2'd1) begin fl.rec_1_unxp <= 1'b1; fl.rec_1 <= 1'b0; end
                            if (bcnt == 2'd2) begin fl.rec_2_unxp <= 1'b1; fl.rec_2 <= 1'b0; end
                        end
                        if (unit_last) begin
                            bcnt          <= bcnt + 2'd1;
                            fl.rec_1      <= (bcnt == 2'd0);
                            fl.rec_2      <= (bcnt == 2'd1);
                            fl.rec_3      <= (bcnt == 2'd2);
                            fl.rec_1_unxp <= 1'b0;
                            fl.rec_2_unxp <= 1'b0;
                        end
                    end
                end
                DOUT: begin
                    if (bitcnt == 3'd0) begin
`ifdef SC_OPI_EN
                        so_r <= opi_m ? 1'b0 : bus.sc_data_out[7];
`else
                        so_r <= bus.sc_data_out[7];
`endif
                        dsh <= {bus.sc_data_out[6:0], 1'b0};
                        if (!fl.r_byte1) begin
                            fl.r_65h_1 <= (bcnt == 2'd0);
                            fl.r_65h_2 <= (bcnt == 2'd1);
                            fl.r_65h_3 <= (bcnt == 2'd2);
                            if (bcnt != 2'd2) bcnt <= bcnt + 2'd1;
                        end
                    end else begin
                        so_r <= dsh[7];
                        dsh  <= {dsh[6:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.so           = so_r;
    assign bus.addr         = addr_r;
    assign bus.data_byte_in = dbi;
    assign bus.pre_data1    = pd1;
    assign bus.pre_data2    = pd2;
    assign bus.w_byte1      = fl.w_byte1;
    assign bus.w_byte2      = fl.w_byte2;
    assign bus.w_71h        = fl.w_71h;
    assign bus.en_wel       = fl.en_wel;
    assign bus.dis_wel      = fl.dis_wel;
    assign bus.opi          = fl.opi;
    assign bus.spi          = fl.spi;
    assign bus.rec_1        = fl.rec_1;
    assign bus.rec_2        = fl.rec_2;
    assign bus.rec_3        = fl.rec_3;
    assign bus.rec_1_unxp   = fl.rec_1_unxp;
    assign bus.rec_2_unxp   = fl.rec_2_unxp;
    assign bus.r_byte1      = fl.r_byte1;
    assign bus.r_65h_1      = fl.r_65h_1;
    assign bus.r_65h_2      = fl.r_65h_2;
    assign bus.r_65h_3      = fl.r_65h_3;
    assign bus.cmd_err      = fl.cmd_err;
endmodule
